xor_stream_cipher: RTL and testbench

Parametrised successor to the single-word XOR encryptor. Holds a multi-word key and XORs a stream of message words against the key words in rotation. Message input and ciphertext output use valid/ready handshakes, with a one-word registered output stage. Sits between the key assembler and the UART/IO framing logic; also serves decryption, since the operation is symmetric.

---
 rtl/xor_cipher_pkg.sv | 20 ++
 rtl/xor_key_store.sv | 34 +++
 rtl/xor_stream_cipher.sv | 151 +++++++++++++++
 tb/tb_xor_stream_cipher.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared types and helpers for the rotating-key XOR stream cipher.
// Optional autokey chaining is selected with the XOR_CIPHER_CHAIN_EN macro.
package xor_cipher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Supported number of key words
   localparam int KEY_LEN_MIN = 2;
   localparam int KEY_LEN_MAX = 16;

   // Next key index, wrapping from len-1 back to 0
   function automatic int wrap_idx(input int idx, input int len);
      return (idx >= len - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/xor_key_store.sv
// Key register file: KEY_LEN words of MSG_SIZE bits, one write port
// (key load or chain update), one combinational read port, async clear.
module xor_key_store #(
   parameter int MSG_SIZE = 8,
   parameter int KEY_LEN  = 4,
   parameter int IDX_W    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [IDX_W-1:0]    waddr,
   input  logic [MSG_SIZE-1:0] wdata,
   input  logic [IDX_W-1:0]    raddr,
   output logic [MSG_SIZE-1:0] rdata
);
   import xor_cipher_pkg::*;

   logic [KEY_LEN-1:0][MSG_SIZE-1:0] key_q, key_d;

   // Single-word write into the key array
   always_comb begin
      key_d = key_q;
      if (we) key_d[waddr] = wdata;
   end

   // Key storage; reset loses the key
   always_ff @(posedge clk or posedge rst) begin
      if (rst) key_q <= '0;
      else     key_q <= key_d;
   end

   assign rdata = key_q[raddr];

endmodule

// File: rtl/xor_stream_cipher.sv
// Rotating multi-word key XOR cipher with valid/ready message input and a
// one-word registered ciphertext output. Symmetric, so it also decrypts.
// Define XOR_CIPHER_CHAIN_EN for autokey chaining (key word replaced by the
// ciphertext-domain word after each accept; iDecrypt picks which word).
module xor_stream_cipher #(
   parameter int MSG_SIZE = 8,
   parameter int KEY_LEN  = 4,
   // Derived; leave at default
   parameter int IDX_W    = $clog2(KEY_LEN)
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iEn,
   input  logic                iKey_Load,
   input  logic                iKey_Valid,
   input  logic [MSG_SIZE-1:0] iKey_Word,
   input  logic                iDecrypt,
   input  logic                iMsg_Valid,
   input  logic [MSG_SIZE-1:0] iMessage,
   output logic                oMsg_Ready,
   output logic [MSG_SIZE-1:0] oCiphertext,
   output logic                oCt_Valid,
   input  logic                iCt_Ready,
   output logic                oKey_Loaded,
   output logic [IDX_W-1:0]    oKey_Idx
);
   import xor_cipher_pkg::*;

   if (KEY_LEN < KEY_LEN_MIN || KEY_LEN > KEY_LEN_MAX) begin : g_bad_key_len
      $error("xor_stream_cipher: KEY_LEN out of range");
   end

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [MSG_SIZE-1:0] ct_q, ct_d;
   logic                ct_vld_q, ct_vld_d;

   logic                key_we;
   logic [IDX_W-1:0]    key_waddr;
   logic [MSG_SIZE-1:0] key_wdata;
   logic [MSG_SIZE-1:0] key_rdata;
   logic [MSG_SIZE-1:0] ct_word;
   logic                msg_ready;
   logic                accept;
   logic                consume;

`ifndef XOR_CIPHER_CHAIN_EN
   // Mode select only matters for chaining
   logic unused_decrypt;
   assign unused_decrypt = iDecrypt;
`endif

   xor_key_store #(
      .MSG_SIZE (MSG_SIZE),
      .KEY_LEN  (KEY_LEN),
      .IDX_W    (IDX_W)
   ) u_key_store (
      .clk   (iClk),
      .rst   (iRst),
      .we    (key_we),
      .waddr (key_waddr),
      .wdata (key_wdata),
      .raddr (idx_q),
      .rdata (key_rdata)
   );

   assign ct_word   = iMessage ^ key_rdata;
   // Room in the output stage if empty or being drained this cycle
   assign msg_ready = iEn && (state_q == RUN) && !iKey_Load && (!ct_vld_q || iCt_Ready);
   assign accept    = iMsg_Valid && msg_ready;
   assign consume   = ct_vld_q && iCt_Ready && iEn;

   // Next-state: FSM, load counter, key index, key writes, output stage
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      ct_d      = ct_q;
      ct_vld_d  = ct_vld_q;
      key_we    = 1'b0;
      key_waddr = cnt_q;
      key_wdata = iKey_Word;

      if (iEn) begin
         if (iKey_Load) begin
            state_d = LOAD;
            cnt_d   = '0;
            idx_d   = '0;
         end else begin
            unique case (state_q)
               LOAD: begin
                  if (iKey_Valid) begin
                     key_we = 1'b1;
                     if (cnt_q == IDX_W'(KEY_LEN - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        idx_d   = '0;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (accept) begin
                     idx_d = IDX_W'(wrap_idx(int'(idx_q), KEY_LEN));
`ifdef XOR_CIPHER_CHAIN_EN
                     key_we    = 1'b1;
                     key_waddr = idx_q;
                     key_wdata = iDecrypt ? iMessage : ct_word;
`endif
                  end
               end
               default: ;
            endcase
         end

         // A pending word is independent of key changes and still drains
         if (accept) begin
            ct_d     = ct_word;
            ct_vld_d = 1'b1;
         end else if (consume) begin
            ct_vld_d = 1'b0;
         end
      end
   end

   // State registers
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         ct_q     <= '0;
         ct_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         ct_q     <= ct_d;
         ct_vld_q <= ct_vld_d;
      end
   end

   assign oMsg_Ready  = msg_ready;
   assign oCiphertext = ct_q;
   assign oCt_Valid   = ct_vld_q;
   assign oKey_Loaded = (state_q == RUN);
   assign oKey_Idx    = idx_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed bench for xor_stream_cipher (MSG_SIZE=8, KEY_LEN=4).
module tb_xor_stream_cipher;

   logic       iClk = 1'b0;
   logic       iRst, iEn, iKey_Load, iKey_Valid, iDecrypt, iMsg_Valid, iCt_Ready;
   logic [7:0] iKey_Word, iMessage;
   logic       oMsg_Ready, oCt_Valid, oKey_Loaded;
   logic [7:0] oCiphertext;
   logic [1:0] oKey_Idx;

   int total = 0;
   int bad   = 0;

`ifdef XOR_CIPHER_CHAIN_EN
   localparam logic [7:0] EXP_A [6] = '{8'hB1, 8'h83, 8'h91, 8'hE7, 8'h15, 8'h26};
   localparam logic [7:0] EXP_B [2] = '{8'hCB, 8'hE8};
`else
   localparam logic [7:0] EXP_A [6] = '{8'hB1, 8'h83, 8'h91, 8'hE7, 8'hB5, 8'h87};
   localparam logic [7:0] EXP_B [2] = '{8'h69, 8'h4B};
`endif

   xor_stream_cipher #(.MSG_SIZE(8), .KEY_LEN(4)) dut (
      .iClk        (iClk),
      .iRst        (iRst),
      .iEn         (iEn),
      .iKey_Load   (iKey_Load),
      .iKey_Valid  (iKey_Valid),
      .iKey_Word   (iKey_Word),
      .iDecrypt    (iDecrypt),
      .iMsg_Valid  (iMsg_Valid),
      .iMessage    (iMessage),
      .oMsg_Ready  (oMsg_Ready),
      .oCiphertext (oCiphertext),
      .oCt_Valid   (oCt_Valid),
      .iCt_Ready   (iCt_Ready),
      .oKey_Loaded (oKey_Loaded),
      .oKey_Idx    (oKey_Idx)
   );

   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic load_key(input logic [7:0] k0, k1, k2, k3);
      iKey_Load = 1'b1; tick();
      iKey_Load = 1'b0; iKey_Valid = 1'b1;
      iKey_Word = k0; tick();
      iKey_Word = k1; tick();
      iKey_Word = k2; tick();
      iKey_Word = k3; tick();
      iKey_Valid = 1'b0;
   endtask

`ifdef XOR_CIPHER_CHAIN_EN
   logic [7:0] msg [8];
   logic [7:0] ctx [8];
`endif

   initial begin
      iRst = 1'b1; iEn = 1'b1; iKey_Load = 1'b0; iKey_Valid = 1'b0; iKey_Word = '0;
      iDecrypt = 1'b0; iMsg_Valid = 1'b0; iMessage = '0; iCt_Ready = 1'b1;
      tick(); tick();
      chk("rst_valid",  oCt_Valid,   0);
      chk("rst_ct",     oCiphertext, 0);
      chk("rst_loaded", oKey_Loaded, 0);
      chk("rst_ready",  oMsg_Ready,  0);
      chk("rst_idx",    oKey_Idx,    0);
      iRst = 1'b0;

      // Message ignored while IDLE
      iMsg_Valid = 1'b1; iMessage = 8'h12; #1;
      chk("idle_ready", oMsg_Ready, 0);
      tick();
      chk("idle_no_ct", oCt_Valid, 0);
      iMsg_Valid = 1'b0;

      load_key(8'h11, 8'h22, 8'h33, 8'h44);
      chk("load_done", oKey_Loaded, 1);
      chk("load_idx",  oKey_Idx,    0);

      // Full-throughput stream, index wraps 3 -> 0
      iMsg_Valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         iMessage = 8'hA0 + 8'(i); #1;
         chk("stream_ready", oMsg_Ready, 1);
         tick();
         chk("stream_ct",  oCiphertext, EXP_A[i]);
         chk("stream_vld", oCt_Valid,   1);
         chk("stream_idx", oKey_Idx,    (i + 1) % 4);
      end
      iMsg_Valid = 1'b0;
      tick();
      chk("drain_vld", oCt_Valid,   0);
      chk("drain_ct",  oCiphertext, EXP_A[5]);

      // Backpressure
      iCt_Ready = 1'b0; iMsg_Valid = 1'b1; iMessage = 8'h5A; #1;
      chk("bp_ready_empty", oMsg_Ready, 1);
      tick();
      chk("bp_ct0", oCiphertext, EXP_B[0]);
      chk("bp_idx0", oKey_Idx, 3);
      iMessage = 8'h0F; #1;
      chk("bp_ready_full", oMsg_Ready, 0);
      tick(); tick();
      chk("bp_ct_hold",  oCiphertext, EXP_B[0]);
      chk("bp_idx_hold", oKey_Idx,    3);
      chk("bp_vld_hold", oCt_Valid,   1);
      iCt_Ready = 1'b1; #1;
      chk("bp_release_ready", oMsg_Ready, 1);
      tick();
      chk("bp_ct1",  oCiphertext, EXP_B[1]);
      chk("bp_idx1", oKey_Idx,    0);
      chk("bp_vld1", oCt_Valid,   1);

      // Key load in RUN beats a simultaneous message; pending word survives
      iCt_Ready = 1'b0; iKey_Load = 1'b1; iMessage = 8'h77; #1;
      chk("kl_ready", oMsg_Ready, 0);
      tick();
      iKey_Load = 1'b0;
      chk("kl_loaded", oKey_Loaded, 0);
      chk("kl_ct",     oCiphertext, EXP_B[1]);
      chk("kl_vld",    oCt_Valid,   1);
      chk("kl_idx",    oKey_Idx,    0);
      iCt_Ready = 1'b1; #1;
      chk("load_ready", oMsg_Ready, 0);
      tick();
      chk("kl_drained", oCt_Valid,   0);
      chk("kl_ct_hold", oCiphertext, EXP_B[1]);
      iMsg_Valid = 1'b0;

      // Load with a 3-cycle enable freeze; frozen words must not land
      iKey_Valid = 1'b1; iKey_Word = 8'h01; tick();
      iEn = 1'b0;
      iKey_Word = 8'hFF; tick();
      iKey_Word = 8'hFE; tick();
      iKey_Word = 8'hFD; tick();
      chk("frz_loaded", oKey_Loaded, 0);
      iEn = 1'b1;
      iKey_Word = 8'h02; tick();
      iKey_Word = 8'h03; tick();
      chk("frz_loaded2", oKey_Loaded, 0);
      iKey_Word = 8'h04; tick();
      iKey_Valid = 1'b0;
      chk("frz_done", oKey_Loaded, 1);
      chk("frz_idx",  oKey_Idx,    0);
      iMsg_Valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         iMessage = 8'(8'h10 * (i + 1)); tick();
         chk("frz_ct", oCiphertext, 8'(8'h11 * (i + 1)));
      end

      // Enable low in RUN holds everything
      iEn = 1'b0; iMessage = 8'h55; #1;
      chk("en0_ready", oMsg_Ready, 0);
      tick();
      chk("en0_ct",  oCiphertext, 8'h44);
      chk("en0_vld", oCt_Valid,   1);
      chk("en0_idx", oKey_Idx,    0);
      iEn = 1'b1;

      // Async reset mid-cycle
      #2 iRst = 1'b1; #1;
      chk("arst_vld",    oCt_Valid,   0);
      chk("arst_ct",     oCiphertext, 0);
      chk("arst_loaded", oKey_Loaded, 0);
      chk("arst_ready",  oMsg_Ready,  0);
      chk("arst_idx",    oKey_Idx,    0);
      iRst = 1'b0;
      tick();
      chk("arst_idle_ready", oMsg_Ready, 0);
      tick();
      chk("arst_idle_vld", oCt_Valid, 0);
      iMsg_Valid = 1'b0;

`ifdef XOR_CIPHER_CHAIN_EN
      // Autokey round trip
      load_key(8'h01, 8'h02, 8'h03, 8'h04);
      iDecrypt = 1'b0; iMsg_Valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         msg[i] = 8'(i * 8'h13 + 8'h05);
         iMessage = msg[i]; tick();
         ctx[i] = oCiphertext;
      end
      iMsg_Valid = 1'b0;
      load_key(8'h01, 8'h02, 8'h03, 8'h04);
      iDecrypt = 1'b1; iMsg_Valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         iMessage = ctx[i]; tick();
         chk("chain_rt", oCiphertext, msg[i]);
      end
      iMsg_Valid = 1'b0; iDecrypt = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
